// File: rtl/fma16_pkg.sv
// Shared half-precision field constants, special values and result-stage types.
package fma16_pkg;

    localparam int EXP_MSB = 14;
    localparam int EXP_LSB = 10;
    localparam int MANT_W  = 10;

    localparam logic [4:0]  EXP_ONES = 5'h1f;

    localparam logic [15:0] QNAN  = 16'h7e00;
    localparam logic [15:0] INF_P = 16'h7c00;
    localparam logic [15:0] INF_N = 16'hfc00;

    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } flags_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } fp16_class_t;

endpackage

// File: rtl/fma16_result_stage_if.sv
// Upstream and downstream beat signals of the fma16 result stage.
interface fma16_result_stage_if #(
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       x;
    logic [15:0]       y;
    logic [15:0]       z;
    logic              add_en;
    logic [15:0]       round_result;
    logic              round_flag;
    logic              overflow_flag;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       result;
    logic [3:0]        flags;
    logic              clr_flags;
    logic [3:0]        flags_acc;
    logic [CNT_W-1:0]  op_count;

    modport master (
        output in_valid, x, y, z, add_en, round_result, round_flag, overflow_flag,
        output out_ready, clr_flags,
        input  in_ready, out_valid, result, flags, flags_acc, op_count
    );

    modport slave (
        input  in_valid, x, y, z, add_en, round_result, round_flag, overflow_flag,
        input  out_ready, clr_flags,
        output in_ready, out_valid, result, flags, flags_acc, op_count
    );

endinterface

// File: rtl/fma16_classify.sv
// Classifies one half-precision operand as zero, infinity, NaN or signalling NaN.
module fma16_classify
    import fma16_pkg::*;
(
    input  logic [15:0]  operand,
    output fp16_class_t  cls
);

    logic [4:0]        expField;
    logic [MANT_W-1:0] mantField;

    assign expField  = operand[EXP_MSB:EXP_LSB];
    assign mantField = operand[MANT_W-1:0];

    // Decode the exponent/mantissa fields into class bits.
    always_comb begin
        cls.is_zero = (operand[14:0] == 15'h0000);
        cls.is_inf  = (expField == EXP_ONES) && (mantField == '0);
        cls.is_nan  = (expField == EXP_ONES) && (mantField != '0);
        cls.is_snan = cls.is_nan && !mantField[MANT_W-1];
    end

endmodule

// File: rtl/fma16_result_stage.sv
// fma16 output stage: special-case override, exception flags, 2-entry skid
// buffer, sticky accrued flags and delivered-beat counter.
module fma16_result_stage
    import fma16_pkg::*;
#(
    parameter int          CNT_W = 16,
    parameter logic [15:0] QNAN  = 16'h7e00
)(
    input  logic                  clk,
    input  logic                  reset_n,
    fma16_result_stage_if.slave   bus
);

    fp16_class_t xCls, yCls, zCls;

    fma16_classify uClassX (.operand(bus.x), .cls(xCls));
    fma16_classify uClassY (.operand(bus.y), .cls(yCls));
    fma16_classify uClassZ (.operand(bus.z), .cls(zCls));

    logic        unusedZZero;
    logic        xs, ys, zs;
    logic        prodInf, nvFlag, anyNan, special;
    logic [15:0] selResult;
    flags_t      curFlags;

    assign unusedZZero = zCls.is_zero;
    assign xs = bus.x[15];
    assign ys = bus.y[15];
    assign zs = bus.z[15];

    // Special-case result selection and per-op exception flags.
    always_comb begin
        prodInf = (xCls.is_inf || yCls.is_inf) && !xCls.is_zero && !yCls.is_zero;
        nvFlag  = xCls.is_snan || yCls.is_snan || (bus.add_en && zCls.is_snan)
                || (xCls.is_inf && yCls.is_zero) || (xCls.is_zero && yCls.is_inf)
                || (bus.add_en && prodInf && zCls.is_inf && ((xs ^ ys) != zs));
        anyNan  = xCls.is_nan || yCls.is_nan || (bus.add_en && zCls.is_nan);
        special = 1'b1;
        if (nvFlag || anyNan) begin
            selResult = QNAN;
        end else if (xCls.is_inf || yCls.is_inf) begin
            selResult = {xs ^ ys, INF_P[14:0]};
        end else if (bus.add_en && zCls.is_inf) begin
            selResult = bus.z;
        end else begin
            selResult = bus.round_result;
            special   = 1'b0;
        end
        curFlags.nv = nvFlag;
        curFlags.of = bus.overflow_flag && !special;
        curFlags.nx = (bus.round_flag || bus.overflow_flag) && !special;
        curFlags.uf = curFlags.nx && (selResult[EXP_MSB:EXP_LSB] == 5'd0);
    end

    logic [15:0] memResult [2];
    flags_t      memFlags  [2];
    logic        wrPtr, rdPtr;
    logic [1:0]  count;
    logic        inHs, outHs;

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.result    = memResult[rdPtr];
    assign bus.flags     = memFlags[rdPtr];
    assign inHs  = bus.in_valid && bus.in_ready;
    assign outHs = bus.out_valid && bus.out_ready;

    // Skid buffer storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            memResult[0] <= '0;
            memResult[1] <= '0;
            memFlags[0]  <= '0;
            memFlags[1]  <= '0;
            wrPtr        <= 1'b0;
            rdPtr        <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (inHs) begin
                memResult[wrPtr] <= selResult;
                memFlags[wrPtr]  <= curFlags;
                wrPtr            <= ~wrPtr;
            end
            if (outHs) begin
                rdPtr <= ~rdPtr;
            end
            case ({inHs, outHs})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    logic [3:0]       accReg;
    logic [CNT_W-1:0] opCnt;

    assign bus.flags_acc = accReg;
    assign bus.op_count  = opCnt;

    // Sticky flags and delivered-beat count; a clear loses to the new beat's flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            accReg <= '0;
            opCnt  <= '0;
        end else begin
            accReg <= (bus.clr_flags ? 4'b0000 : accReg) | (outHs ? bus.flags : 4'b0000);
            if (outHs) begin
                opCnt <= opCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fma16_result_stage.sv
// Directed-vector bench for fma16_result_stage.
module tb_fma16_result_stage;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    fma16_result_stage_if #(.CNT_W(16)) bus ();

    fma16_result_stage #(.CNT_W(16), .QNAN(16'h7e00)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic        addEn;
        logic [15:0] rr;
        logic        rf;
        logic        of;
        logic [15:0] expRes;
        logic [3:0]  expFlags;
    } vec_t;

    vec_t        vecs [14];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [3:0]  expAcc;
    logic [15:0] expCnt;
    logic [15:0] got [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic setInputs(input vec_t v);
        bus.x             = v.x;
        bus.y             = v.y;
        bus.z             = v.z;
        bus.add_en        = v.addEn;
        bus.round_result  = v.rr;
        bus.round_flag    = v.rf;
        bus.overflow_flag = v.of;
    endtask

    // One beat through an empty buffer with out_ready high.
    task automatic sendBeat(input vec_t v, input logic clr, input string name);
        setInputs(v);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        check({name, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({name, ".result"}, {16'd0, bus.result}, {16'd0, v.expRes});
        check({name, ".flags"}, {28'd0, bus.flags}, {28'd0, v.expFlags});
        bus.clr_flags = clr;
        @(posedge clk); #1;
        bus.clr_flags = 1'b0;
        expAcc = (clr ? 4'b0000 : expAcc) | v.expFlags;
        expCnt = expCnt + 16'd1;
        check({name, ".acc"}, {28'd0, bus.flags_acc}, {28'd0, expAcc});
        check({name, ".count"}, {16'd0, bus.op_count}, {16'd0, expCnt});
        check({name, ".drained"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        expAcc = 4'b0000;
        expCnt = 16'd0;
    endtask

    vec_t v;

    initial begin
        //          x        y        z        add  rr       rf    of    expRes   expFlags
        vecs[0]  = {16'h7c00, 16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h7e00, 4'b1000};
        vecs[1]  = {16'h3c00, 16'h4000, 16'h0000, 1'b0, 16'h4000, 1'b0, 1'b0, 16'h4000, 4'b0000};
        vecs[2]  = {16'h3c00, 16'h3c00, 16'h0000, 1'b0, 16'h7c00, 1'b0, 1'b1, 16'h7c00, 4'b0101};
        vecs[3]  = {16'h3c00, 16'h3c00, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h0001, 4'b0011};
        vecs[4]  = {16'h7c00, 16'h3c00, 16'hfc00, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h7e00, 4'b1000};
        vecs[5]  = {16'h7c00, 16'h3c00, 16'h7c00, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h7c00, 4'b0000};
        vecs[6]  = {16'h7c01, 16'h3c00, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h7e00, 4'b1000};
        vecs[7]  = {16'h7e00, 16'h3c00, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h7e00, 4'b0000};
        vecs[8]  = {16'h3c00, 16'h3c00, 16'h7c01, 1'b0, 16'h3c00, 1'b0, 1'b0, 16'h3c00, 4'b0000};
        vecs[9]  = {16'h3c00, 16'h3c00, 16'h7c01, 1'b1, 16'h3c00, 1'b0, 1'b0, 16'h7e00, 4'b1000};
        vecs[10] = {16'h3c00, 16'h3c00, 16'hfc00, 1'b1, 16'h1111, 1'b1, 1'b0, 16'hfc00, 4'b0000};
        vecs[11] = {16'h8000, 16'hfc00, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h7e00, 4'b1000};
        vecs[12] = {16'hc000, 16'h7c00, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b1, 16'hfc00, 4'b0000};
        vecs[13] = {16'h3c00, 16'h3c00, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0011};

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.clr_flags = 1'b0;
        setInputs(vecs[1]);
        expAcc = 4'b0000;
        expCnt = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst.result", {16'd0, bus.result}, 32'h0);
        check("rst.flags", {28'd0, bus.flags}, 32'h0);
        check("rst.acc", {28'd0, bus.flags_acc}, 32'h0);
        check("rst.count", {16'd0, bus.op_count}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            sendBeat(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Backpressure: A and B accepted, C held until space frees up.
        doReset();
        bus.out_ready = 1'b0;
        v = vecs[1];
        v.rr = 16'h1111; setInputs(v); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        v.rr = 16'h2222; setInputs(v);
        @(posedge clk); #1;
        check("bp.in_ready_full", {31'd0, bus.in_ready}, 32'd0);
        v.rr = 16'h3333; setInputs(v);
        @(posedge clk); #1;
        check("bp.in_ready_held", {31'd0, bus.in_ready}, 32'd0);
        check("bp.out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp.head_stable", {16'd0, bus.result}, 32'h1111);
        bus.out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            logic hsIn;
            @(negedge clk);
            hsIn = bus.in_valid & bus.in_ready;
            if (bus.out_valid & bus.out_ready) got.push_back(bus.result);
            @(posedge clk); #1;
            if (hsIn) bus.in_valid = 1'b0;
        end
        check("bp.beats", got.size(), 32'd3);
        if (got.size() == 3) begin
            check("bp.order0", {16'd0, got[0]}, 32'h1111);
            check("bp.order1", {16'd0, got[1]}, 32'h2222);
            check("bp.order2", {16'd0, got[2]}, 32'h3333);
        end
        check("bp.count", {16'd0, bus.op_count}, 32'd3);
        check("bp.empty", {31'd0, bus.out_valid}, 32'd0);
        expCnt = 16'd3;

        // Mid-operation reset with two beats buffered and in_valid still high.
        sendBeat(vecs[2], 1'b0, "prerst");
        bus.out_ready = 1'b0;
        setInputs(vecs[3]);
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mr.full", {31'd0, bus.in_ready}, 32'd0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.in_valid = 1'b0;
        expAcc = 4'b0000;
        expCnt = 16'd0;
        check("mr.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mr.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mr.acc", {28'd0, bus.flags_acc}, 32'h0);
        check("mr.count", {16'd0, bus.op_count}, 32'h0);
        check("mr.result", {16'd0, bus.result}, 32'h0);
        bus.out_ready = 1'b1;

        // Clear coinciding with delivery keeps only the new beat's flags.
        sendBeat(vecs[2], 1'b0, "preclr");
        v = vecs[1];
        v.rr = 16'h3c01; v.rf = 1'b1; v.expRes = 16'h3c01; v.expFlags = 4'b0001;
        sendBeat(v, 1'b1, "clr");

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fma16_result_stage.md
Name: fma16_result_stage

Overview:
- Registered output stage directly downstream of the fma16 rounding logic.
- Takes the rounded sum, the rounding and overflow indications, and the original operands.
- Overrides the result for IEEE special cases (NaN, invalid, infinities) and computes per-operation exception flags {NV, OF, UF, NX}.
- Presents result and flags on a valid/ready interface through a 2-entry skid buffer, and maintains a sticky accrued-flags register plus a completed-operation counter.

Parameters:
- CNT_W, 16, width of the completed-operation counter.
- QNAN, 16'h7e00, canonical quiet NaN returned for any NaN or invalid result.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- x, y, z  in  16  original half-precision operands.
- add_en  in  1  z participates; when 0, z is ignored for the special-case and invalid checks.
- round_result  in  16  rounded value from the rounding stage.
- round_flag  in  1  rounding altered or discarded nonzero bits.
- overflow_flag  in  1  exponent overflow detected upstream.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts.
- result  out  16  final half-precision result.
- flags  out  4  per-op flags {NV, OF, UF, NX}.
- clr_flags  in  1  clear accrued flags.
- flags_acc  out  4  sticky OR of the flags of all delivered beats.
- op_count  out  CNT_W  number of delivered beats, wraps modulo 2^CNT_W.

Behaviour:
- Classification (combinational, from in-side operands):
  - inf: exp == 5'h1f and mant == 0.
  - NaN: exp == 5'h1f and mant != 0; sNaN additionally has mant[9] == 0.
  - zero: bits[14:0] == 0.
- NV = any sNaN among x, y (and z if add_en) | (x inf & y zero) | (x zero & y inf) | (add_en & product inf & z inf & (xs^ys) != zs), where product inf = (x inf | y inf) with neither operand zero.
- Result select, first match wins:
  1. NV or any NaN operand -> QNAN.
  2. x or y inf -> {xs^ys, 15'h7c00}.
  3. add_en & z inf -> z.
  4. Otherwise -> round_result.
- Per-op flags:
  - special = select path 1, 2 or 3.
  - OF = overflow_flag & ~special.
  - NX = (round_flag | overflow_flag) & ~special.
  - UF = NX & (selected result exp == 0).
  - NV as computed above.
- Skid buffer: 2 entries of {result, flags}, FIFO order.
  - Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
  - in_ready = ~full, a registered count-based signal; it does not depend combinationally on out_ready.
  - out_valid = ~empty.
  - Latency is 1 cycle: a beat accepted at edge N appears at out_* after edge N when the buffer was empty.
  - Simultaneous input and output handshakes leave the count unchanged and preserve order.
  - With out_ready held low, at most 2 beats are accepted; in_ready deasserts the cycle after the second accept.
  - result and flags hold stable while out_valid & ~out_ready.
- flags_acc <= (clr_flags ? 0 : flags_acc) | (output handshake ? flags : 0). A same-cycle clear and handshake leaves only the new beat's flags.
- op_count increments on each output handshake and wraps to 0 after the maximum value.
- Reset (synchronous, reset_n == 0 at an edge), including mid-operation:
  - Buffer emptied; out_valid = 0, in_ready = 1.
  - result = 16'h0000, flags = 0, flags_acc = 0, op_count = 0.
  - Beats in flight are discarded. in_valid is ignored during the reset cycle.

Decomposition:
- Shared package fma16_pkg:
  - Field constants: EXP_MSB = 14, EXP_LSB = 10, MANT_W = 10, EXP_ONES = 5'h1f.
  - Values: QNAN, INF_P = 16'h7c00, INF_N = 16'hfc00.
  - Typedef flags_t, a packed struct {nv, of, uf, nx}.
  - Typedef fp16_class_t = {is_zero, is_inf, is_nan, is_snan}.
- Sub-module fma16_classify: one 16-bit operand in, fp16_class_t out. Instantiated three times.
- The skid buffer stays inline.

Test Plan:
- x=16'h7c00, y=16'h0000, add_en=0, round_result=16'h1234 -> result 16'h7e00, flags 4'b1000.
- x=16'h3c00, y=16'h4000, z=16'h0000, round_result=16'h4000, round_flag=0, overflow_flag=0 -> result 16'h4000, flags 4'b0000, op_count 1.
- round_result=16'h7c00, overflow_flag=1, finite operands -> result 16'h7c00, flags 4'b0101. Then round_result=16'h0001, round_flag=1 -> flags 4'b0011, flags_acc 4'b0111.
- add_en=1, x=16'h7c00, y=16'h3c00, z=16'hfc00 -> result 16'h7e00, NV=1. Same operands with z=16'h7c00 -> result 16'h7c00, flags 0.
- out_ready=0, three consecutive in_valid beats A, B, C -> A and B accepted, in_ready=0 while C is held. Raise out_ready -> outputs A, B, C in order, op_count 3.
- Two beats buffered, assert reset_n=0 for one cycle -> out_valid=0, in_ready=1, flags_acc=0, op_count=0 on the next cycle. clr_flags together with a beat carrying flags=4'b0001 -> flags_acc=4'b0001.
